// File: rtl/ctrl_reg_sequencer_pkg.sv
// Shared types for the control-register sequencer.
// System-state encoding, register map and FSM states.
package madnes_ctrl_pkg;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    LOADING   = 2'd1,
    BOOTSTRAP = 2'd2
  } sys_state_e;

  localparam logic [2:0] ADDR_PALETTE = 3'b000;
  localparam logic [2:0] ADDR_STATE   = 3'b001;

  typedef enum logic [2:0] {
    S_BOOT_WR,
    S_BOOT_WAIT,
    S_NORM_WR,
    S_NORMAL,
    S_LOADING,
    S_ERROR
  } fsm_state_e;

  function automatic logic [7:0] state_byte(
    input sys_state_e s
  );
    return {6'b0, s};
  endfunction

endpackage

// File: rtl/ctrl_reg_sequencer_if.sv
// MCU write-request handshake bundle.
// Request held with addr/data stable until a one-cycle ack.
interface ctrl_reg_sequencer_if;

  logic       mcu_req;
  logic [2:0] mcu_addr;
  logic [7:0] mcu_data;
  logic       mcu_ack;

  modport master (
    output mcu_req,
    output mcu_addr,
    output mcu_data,
    input  mcu_ack
  );

  modport slave (
    input  mcu_req,
    input  mcu_addr,
    input  mcu_data,
    output mcu_ack
  );

endinterface

// File: rtl/ctrl_reg_sequencer.sv
// Boot/normal/loading sequencer arbitrating MCU writes
// into the control register file; all outputs registered.
module ctrl_reg_sequencer
  import madnes_ctrl_pkg::*;
#(
  parameter int BOOT_TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  ctrl_reg_sequencer_if.slave  mcu,
  input  logic                 vblank,
  input  logic                 boot_done,
  output logic [2:0]           reg_write_addr,
  output logic [7:0]           reg_write_data,
  output logic                 reg_write_enable,
  output logic [1:0]           state_out,
  output logic                 boot_error
);

  localparam int CW =
    (BOOT_TIMEOUT > 1) ? $clog2(BOOT_TIMEOUT) : 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(BOOT_TIMEOUT - 1);

  fsm_state_e fsm_q, fsm_d;
  cnt_t       cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic       we_q, we_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  sys_state_e sys_q, sys_d;
  logic       err_q, err_d;

  logic in_run;
  logic in_load;
  logic take;
  logic is_pal;
  logic is_st;
  logic pal_ok;
  logic pal_stall;
  logic go_load;
  logic go_norm;

  // A request cannot land while the previous ack or write
  // is still on the outputs; this enforces the idle gap.
  assign in_run  = (fsm_q == S_NORMAL) || (fsm_q == S_LOADING);
  assign in_load = (fsm_q == S_LOADING);
  assign take    = in_run && mcu.mcu_req && !ack_q && !we_q;

  assign is_pal    = (mcu.mcu_addr == ADDR_PALETTE);
  assign is_st     = (mcu.mcu_addr == ADDR_STATE);
  assign pal_ok    = is_pal && (in_load || vblank);
  assign pal_stall = is_pal && !pal_ok;
  assign go_load   = is_st && !in_load &&
                     (mcu.mcu_data[1:0] == 2'd1);
  assign go_norm   = is_st && in_load &&
                     (mcu.mcu_data[1:0] == 2'd0);

  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    ack_d  = 1'b0;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    sys_d  = sys_q;
    err_d  = err_q;

    unique case (fsm_q)
      S_BOOT_WR: begin
        we_d   = 1'b1;
        addr_d = ADDR_STATE;
        data_d = state_byte(BOOTSTRAP);
        sys_d  = BOOTSTRAP;
        cnt_d  = '0;
        fsm_d  = S_BOOT_WAIT;
      end
      S_BOOT_WAIT: begin
        if (boot_done) begin
          fsm_d = S_NORM_WR;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          fsm_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      S_NORM_WR: begin
        we_d   = 1'b1;
        addr_d = ADDR_STATE;
        data_d = state_byte(NORMAL);
        sys_d  = NORMAL;
        fsm_d  = S_NORMAL;
      end
      S_NORMAL, S_LOADING: begin
        if (take && !pal_stall) begin
          ack_d = 1'b1;
          unique case (1'b1)
            pal_ok: begin
              we_d   = 1'b1;
              addr_d = ADDR_PALETTE;
              data_d = mcu.mcu_data;
            end
            go_load: begin
              we_d   = 1'b1;
              addr_d = ADDR_STATE;
              data_d = state_byte(LOADING);
              sys_d  = LOADING;
              fsm_d  = S_LOADING;
            end
            go_norm: begin
              we_d   = 1'b1;
              addr_d = ADDR_STATE;
              data_d = state_byte(NORMAL);
              sys_d  = NORMAL;
              fsm_d  = S_NORMAL;
            end
            default: begin
              we_d = 1'b0;
            end
          endcase
        end
      end
      S_ERROR: begin
        fsm_d = S_ERROR;
      end
      default: begin
        fsm_d = S_BOOT_WR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= S_BOOT_WR;
      cnt_q  <= '0;
      ack_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sys_q  <= BOOTSTRAP;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      ack_q  <= ack_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sys_q  <= sys_d;
      err_q  <= err_d;
    end
  end

  assign mcu.mcu_ack      = ack_q;
  assign reg_write_enable = we_q;
  assign reg_write_addr   = addr_q;
  assign reg_write_data   = data_q;
  assign state_out        = sys_q;
  assign boot_error       = err_q;

endmodule
